// File: rtl/vx_lzc_pipe.sv
// vx_lzc_pipe: two-stage segmented multi-lane zero counter with valid/ready; define VX_LZC_PIPE_MODE_EN for per-transaction direction
module vx_lzc_pipe #(
  parameter int N = 32,
  parameter int LANES = 1,
  parameter int SEGS = 4,
  parameter int REVERSE = 0,
  parameter int TAGW = 1,
  parameter int CNTW = $clog2(N + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  valid_in,
  output logic                  ready_in,
  input  logic [LANES*N-1:0]    data_in,
  input  logic                  mode_in,
  input  logic [TAGW-1:0]       tag_in,
  output logic                  valid_out,
  input  logic                  ready_out,
  output logic [LANES*CNTW-1:0] count_out,
  output logic [LANES-1:0]      zero_out,
  output logic [TAGW-1:0]       tag_out
);
  localparam int SEGW = N / SEGS;
  localparam int SCW = SEGW > 1 ? $clog2(SEGW) : 1;
  logic dir_in, dir_s1;
  logic s1_valid, s2_adv;
  logic [TAGW-1:0] s1_tag;
  logic [LANES-1:0][SEGS-1:0] nz_d, s1_nz;
  logic [LANES-1:0][SEGS-1:0][SCW-1:0] cnt_d, s1_cnt;
  logic [LANES*CNTW-1:0] count_d;
  logic [LANES-1:0] zero_d;
`ifdef VX_LZC_PIPE_MODE_EN
  logic s1_mode;
  localparam logic UNUSED_REV = REVERSE != 0;
  assign dir_in = mode_in;
  assign dir_s1 = s1_mode;
`else
  logic unused_mode;
  assign unused_mode = mode_in;
  assign dir_in = REVERSE != 0;
  assign dir_s1 = REVERSE != 0;
`endif
  function automatic logic [SCW-1:0] seg_zeros(input logic [SEGW-1:0] v, input logic trail);
    seg_zeros = '0;
    for (int i = 0; i < SEGW; i++)
      if (v[i] && !trail) seg_zeros = SCW'(SEGW - 1 - i);
    for (int i = SEGW - 1; i >= 0; i--)
      if (v[i] && trail) seg_zeros = SCW'(i);
  endfunction
  assign s2_adv = !valid_out || ready_out;
  assign ready_in = !s1_valid || s2_adv;
  // per-segment nonzero flag and in-segment zero count
  always_comb begin
    nz_d = '0;
    cnt_d = '0;
    for (int l = 0; l < LANES; l++)
      for (int s = 0; s < SEGS; s++) begin
        nz_d[l][s] = |data_in[l*N + s*SEGW +: SEGW];
        cnt_d[l][s] = seg_zeros(data_in[l*N + s*SEGW +: SEGW], dir_in);
      end
  end
  // combine segments: skipped all-zero segments times SEGW plus the first nonzero segment's count
  always_comb begin
    count_d = '0;
    zero_d = '1;
    for (int l = 0; l < LANES; l++) begin
      for (int j = 0; j < SEGS; j++)
        if (zero_d[l] && s1_nz[l][dir_s1 ? j : SEGS - 1 - j]) begin
          zero_d[l] = 1'b0;
          count_d[l*CNTW +: CNTW] = CNTW'(j * SEGW) + CNTW'(s1_cnt[l][dir_s1 ? j : SEGS - 1 - j]);
        end
      if (zero_d[l]) count_d[l*CNTW +: CNTW] = CNTW'(N);
    end
  end
  // stage 1 occupancy
  always_ff @(posedge clk) begin
    if (reset) s1_valid <= 1'b0;
    else if (ready_in) s1_valid <= valid_in;
  end
  // stage 1 payload, captured only on an input transfer
  always_ff @(posedge clk) begin
    if (valid_in && ready_in) begin
      s1_nz <= nz_d;
      s1_cnt <= cnt_d;
      s1_tag <= tag_in;
`ifdef VX_LZC_PIPE_MODE_EN
      s1_mode <= mode_in;
`endif
    end
  end
  // stage 2 result register, held while the consumer stalls
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_out <= 1'b0;
      count_out <= '0;
      zero_out <= '0;
      tag_out <= '0;
    end else if (s2_adv) begin
      valid_out <= s1_valid;
      if (s1_valid) begin
        count_out <= count_d;
        zero_out <= zero_d;
        tag_out <= s1_tag;
      end
    end
  end
endmodule
